// File: rtl/mc_interface_fsm_if.sv
// ---------------------------------------------------------------------------
// mc_interface_fsm_if
// Bundles the request/acknowledge handshake and the status outputs of
// mc_interface_fsm. The arbiter side connects through the slave modport and
// the requester/holder side (or a testbench) connects through the master
// modport.
//
// Handshake semantics (level based, no valid/ready pairing):
//   input_request[i]      level, held by channel i while it wants service
//   grant[i]              one-hot, stable from IDLE exit until IDLE return
//   output_is_ready       level from the output holder while in PROCESSING
//   done[i]               level toward the granted channel while in DONE
//   output_acknowledge[i] level from channel i; only the granted bit counts
//
// Signals:
//   input_request, output_acknowledge, output_is_ready, abort, timeout_limit
//     -> driven by master
//   state_out, grant, active_ch, start, done, timeout_err, busy
//     -> driven by slave
// ---------------------------------------------------------------------------
interface mc_interface_fsm_if #(
  parameter int NUM_CH = 4,
  parameter int TMO_W  = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] input_request;
  logic [NUM_CH-1:0] output_acknowledge;
  logic              output_is_ready;
  logic              abort;
  logic [TMO_W-1:0]  timeout_limit;

  logic [1:0]        state_out;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   active_ch;
  logic              start;
  logic [NUM_CH-1:0] done;
  logic              timeout_err;
  logic              busy;

  modport master (
    output input_request, output_acknowledge, output_is_ready, abort,
           timeout_limit,
    input  state_out, grant, active_ch, start, done, timeout_err, busy
  );

  modport slave (
    input  input_request, output_acknowledge, output_is_ready, abort,
           timeout_limit,
    output state_out, grant, active_ch, start, done, timeout_err, busy
  );
endinterface

// File: rtl/mc_interface_fsm.sv
// ---------------------------------------------------------------------------
// mc_interface_fsm
// Round-robin arbiter plus transaction FSM for NUM_CH requester channels.
// One channel is granted at a time and walked through
// IDLE -> PROCESSING -> DONE -> IDLE, with an optional processing timeout
// (IDLE -> PROCESSING -> TIMEOUT -> IDLE) and a synchronous abort.
//
// Ports:
//   clk   clock
//   nrst  asynchronous active-low reset
//   bus   mc_interface_fsm_if.slave
//         in : input_request, output_acknowledge, output_is_ready, abort,
//              timeout_limit (0 disables the timeout)
//         out: state_out (IDLE=0 PROCESSING=1 DONE=2 TIMEOUT=3), grant,
//              active_ch, start, done, timeout_err, busy
//
// Every output is a register or a decode of registered state only.
// ---------------------------------------------------------------------------
module mc_interface_fsm #(
  parameter int NUM_CH = 4,
  parameter int TMO_W  = 8
) (
  input logic              clk,
  input logic              nrst,
  mc_interface_fsm_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PROC    = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [CH_W-1:0]   active_ch_q, active_ch_d;
  logic              start_q, start_d;
  logic [TMO_W-1:0]  timer_q, timer_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;   // index of the last granted channel

  logic              req_found;
  logic [CH_W-1:0]   sel_idx;
  logic [CH_W-1:0]   cand;
  logic              tmo_hit;

  // Round-robin pick. Candidates are visited farthest-first so that the
  // nearest requesting channel after rr_ptr_q is the last one assigned.
  always_comb begin
    req_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      cand = CH_W'((int'(rr_ptr_q) + i) % NUM_CH);
      if (bus.input_request[cand]) begin
        req_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Expiry fires on the cycle whose timer equals limit-1, so the FSM spends
  // exactly timeout_limit cycles in PROCESSING before leaving.
  assign tmo_hit = (bus.timeout_limit != '0) &&
                   (timer_q == bus.timeout_limit - TMO_W'(1));

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    active_ch_d = active_ch_q;
    start_d     = 1'b0;
    timer_d     = timer_q;
    rr_ptr_d    = rr_ptr_q;

    case (state_q)
      ST_IDLE: begin
        if (req_found) begin
          state_d     = ST_PROC;
          grant_d     = {{(NUM_CH-1){1'b0}}, 1'b1} << sel_idx;
          active_ch_d = sel_idx;
          rr_ptr_d    = sel_idx;   // next search starts one past this channel
          start_d     = 1'b1;
          timer_d     = '0;
        end
      end

      ST_PROC: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bus.output_is_ready) begin
          state_d = ST_DONE;       // wins over a simultaneous expiry
        end else if (tmo_hit) begin
          state_d = ST_TIMEOUT;
        end else if (timer_q != '1) begin
          timer_d = timer_q + TMO_W'(1);
        end
      end

      ST_DONE: begin
        if (bus.abort || bus.output_acknowledge[active_ch_q]) begin
          state_d = ST_IDLE;
        end
      end

      ST_TIMEOUT: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Grant is only meaningful outside IDLE; drop it on every IDLE return.
    if (state_d == ST_IDLE && state_q != ST_IDLE) begin
      grant_d     = '0;
      active_ch_d = '0;
      timer_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      active_ch_q <= '0;
      start_q     <= 1'b0;
      timer_q     <= '0;
      rr_ptr_q    <= CH_W'(NUM_CH - 1);
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      active_ch_q <= active_ch_d;
      start_q     <= start_d;
      timer_q     <= timer_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.state_out   = state_q;
  assign bus.grant       = grant_q;
  assign bus.active_ch   = active_ch_q;
  assign bus.start       = start_q;
  assign bus.done        = (state_q == ST_DONE) ? grant_q : '0;
  assign bus.timeout_err = (state_q == ST_TIMEOUT);
  assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mc_interface_fsm.sv
module tb_mc_interface_fsm;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PROC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_TMO  = 2'd3;

  typedef struct {
    logic [3:0] req;
    logic [3:0] ack;
    logic       rdy;
    logic       abt;
    logic [1:0] st;
    logic [3:0] gnt;
    logic [1:0] act;
    logic       stt;
    logic [3:0] dn;
    logic       terr;
  } vec_t;

  logic clk;
  logic nrst;
  int   checks;
  int   errors;
  vec_t tbl[$];

  mc_interface_fsm_if #(.NUM_CH(4), .TMO_W(8)) bus ();

  mc_interface_fsm #(.NUM_CH(4), .TMO_W(8)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] req, input logic [3:0] ack,
                       input logic rdy, input logic abt);
    bus.input_request      = req;
    bus.output_acknowledge = ack;
    bus.output_is_ready    = rdy;
    bus.abort              = abt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input int unsigned act,
                     input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] st,
                           input logic [3:0] g, input logic [1:0] a,
                           input logic s, input logic [3:0] d,
                           input logic te);
    chk({tag, " state"}, 32'(bus.state_out), 32'(st));
    chk({tag, " grant"}, 32'(bus.grant), 32'(g));
    chk({tag, " active_ch"}, 32'(bus.active_ch), 32'(a));
    chk({tag, " start"}, 32'(bus.start), 32'(s));
    chk({tag, " done"}, 32'(bus.done), 32'(d));
    chk({tag, " timeout_err"}, 32'(bus.timeout_err), 32'(te));
    chk({tag, " busy"}, 32'(bus.busy), (st != S_IDLE) ? 32'd1 : 32'd0);
  endtask

  function automatic vec_t mk(input logic [3:0] req, input logic [3:0] ack,
                              input logic rdy, input logic abt,
                              input logic [1:0] st, input logic [3:0] gnt,
                              input logic [1:0] act, input logic stt,
                              input logic [3:0] dn, input logic terr);
    vec_t v;
    v.req = req; v.ack = ack; v.rdy = rdy; v.abt = abt;
    v.st = st; v.gnt = gnt; v.act = act; v.stt = stt; v.dn = dn;
    v.terr = terr;
    return v;
  endfunction

  // ---------------- test ----------------
  initial begin
    logic [3:0] g;
    int         not_proc;
    checks = 0;
    errors = 0;
    nrst   = 1'b0;
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    bus.timeout_limit = 8'd0;

    // Fairness: all four request, ready/ack held high -> 0,1,2,3,0,1,2,3.
    for (int n = 0; n < 8; n++) begin
      g = 4'b0001 << (n % 4);
      tbl.push_back(mk(4'b1111, 4'b1111, 1'b1, 1'b0, S_PROC, g, 2'(n % 4), 1'b1, 4'b0000, 1'b0));
      tbl.push_back(mk(4'b1111, 4'b1111, 1'b1, 1'b0, S_DONE, g, 2'(n % 4), 1'b0, g, 1'b0));
      tbl.push_back(mk(4'b1111, 4'b1111, 1'b1, 1'b0, S_IDLE, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0));
    end
    // Single request on ch2, ready after 5 processing cycles, ack[2].
    tbl.push_back(mk(4'b0100, 4'b0000, 1'b0, 1'b0, S_PROC, 4'b0100, 2'd2, 1'b1, 4'b0000, 1'b0));
    for (int n = 0; n < 4; n++)
      tbl.push_back(mk(4'b0000, 4'b0000, 1'b0, 1'b0, S_PROC, 4'b0100, 2'd2, 1'b0, 4'b0000, 1'b0));
    tbl.push_back(mk(4'b0000, 4'b0000, 1'b1, 1'b0, S_DONE, 4'b0100, 2'd2, 1'b0, 4'b0100, 1'b0));
    tbl.push_back(mk(4'b0000, 4'b0000, 1'b0, 1'b0, S_DONE, 4'b0100, 2'd2, 1'b0, 4'b0100, 1'b0));
    tbl.push_back(mk(4'b0000, 4'b0100, 1'b0, 1'b0, S_IDLE, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0));
    // ch3 granted; wrong ack ignored; abort in DONE; abort in IDLE no effect;
    // abort in PROCESSING.
    tbl.push_back(mk(4'b1000, 4'b0000, 1'b0, 1'b0, S_PROC, 4'b1000, 2'd3, 1'b1, 4'b0000, 1'b0));
    tbl.push_back(mk(4'b0000, 4'b0000, 1'b1, 1'b0, S_DONE, 4'b1000, 2'd3, 1'b0, 4'b1000, 1'b0));
    tbl.push_back(mk(4'b0000, 4'b0010, 1'b0, 1'b0, S_DONE, 4'b1000, 2'd3, 1'b0, 4'b1000, 1'b0));
    tbl.push_back(mk(4'b0000, 4'b0000, 1'b0, 1'b1, S_IDLE, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0));
    tbl.push_back(mk(4'b0001, 4'b0000, 1'b0, 1'b1, S_PROC, 4'b0001, 2'd0, 1'b1, 4'b0000, 1'b0));
    tbl.push_back(mk(4'b0000, 4'b0000, 1'b1, 1'b1, S_IDLE, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0));

    // Reset values while nrst is held low.
    #12;
    check_all("reset", S_IDLE, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
    #10;
    nrst = 1'b1;
    #1;

    foreach (tbl[i]) begin
      drive(tbl[i].req, tbl[i].ack, tbl[i].rdy, tbl[i].abt);
      step();
      check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].gnt, tbl[i].act,
                tbl[i].stt, tbl[i].dn, tbl[i].terr);
    end

    // Timeout, limit 10: ch1 granted (last was ch0), 10 processing cycles,
    // one TIMEOUT cycle, then the next grant skips ch1.
    bus.timeout_limit = 8'd10;
    drive(4'b0011, 4'b0000, 1'b0, 1'b0);
    step();
    check_all("tmo grant", S_PROC, 4'b0010, 2'd1, 1'b1, 4'b0000, 1'b0);
    for (int i = 1; i < 10; i++) begin
      step();
      chk($sformatf("tmo proc%0d state", i), 32'(bus.state_out), 32'(S_PROC));
    end
    step();
    check_all("tmo hit", S_TMO, 4'b0010, 2'd1, 1'b0, 4'b0000, 1'b1);
    step();
    check_all("tmo exit", S_IDLE, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
    step();
    check_all("tmo regrant", S_PROC, 4'b0001, 2'd0, 1'b1, 4'b0000, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0, 1'b1);
    step();
    check_all("tmo abort", S_IDLE, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);

    // Limit 0: never times out, timer saturates without wrapping.
    bus.timeout_limit = 8'd0;
    drive(4'b0100, 4'b0000, 1'b0, 1'b0);
    step();
    check_all("nolimit grant", S_PROC, 4'b0100, 2'd2, 1'b1, 4'b0000, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    not_proc = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (bus.state_out != S_PROC || bus.timeout_err) not_proc++;
    end
    chk("nolimit left proc", 32'(not_proc), 32'd0);
    drive(4'b0000, 4'b0000, 1'b0, 1'b1);
    step();
    chk("nolimit abort state", 32'(bus.state_out), 32'(S_IDLE));

    // Race, limit 4: ready on the expiry cycle resolves to DONE.
    bus.timeout_limit = 8'd4;
    drive(4'b1000, 4'b0000, 1'b0, 1'b0);
    step();
    check_all("race grant", S_PROC, 4'b1000, 2'd3, 1'b1, 4'b0000, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step();
    chk("race pre state", 32'(bus.state_out), 32'(S_PROC));
    drive(4'b0000, 4'b0000, 1'b1, 1'b0);
    step();
    check_all("race done", S_DONE, 4'b1000, 2'd3, 1'b0, 4'b1000, 1'b0);
    drive(4'b0000, 4'b1000, 1'b0, 1'b0);
    step();
    check_all("race exit", S_IDLE, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);

    // Async reset mid-PROCESSING, then the pointer restarts at ch0.
    bus.timeout_limit = 8'd0;
    drive(4'b0010, 4'b0000, 1'b0, 1'b0);
    step();
    check_all("arst grant", S_PROC, 4'b0010, 2'd1, 1'b1, 4'b0000, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    #2;
    nrst = 1'b0;
    #1;
    check_all("arst async", S_IDLE, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
    step();
    nrst = 1'b1;
    drive(4'b1101, 4'b0000, 1'b0, 1'b0);
    step();
    check_all("arst first", S_PROC, 4'b0001, 2'd0, 1'b1, 4'b0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard ceiling so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/mc_interface_fsm.md
MC_INTERFACE_FSM -- requirements
Module: mc_interface_fsm

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning number of requester channels (legal 2..16).
REQ-002 The block SHALL have parameter TMO_W, default 8, meaning width of the processing-timeout counter.
REQ-003 The block SHALL have reset nrst, asynchronous, active-low, and clock clk.
REQ-004 Port list (name direction width meaning):
 - clk  in  1  clock
 - nrst  in  1  async active-low reset
 - input_request  in  NUM_CH  per-channel request level
 - output_acknowledge  in  NUM_CH  per-channel acknowledge level
 - output_is_ready  in  1  result valid from output holder
 - abort  in  1  synchronous abort of current transaction
 - timeout_limit  in  TMO_W  max PROCESSING cycles; 0 disables timeout
 - state_out  out  2  current state: IDLE=0, PROCESSING=1, DONE=2, TIMEOUT=3
 - grant  out  NUM_CH  one-hot granted channel, zero in IDLE
 - active_ch  out  $clog2(NUM_CH)  index of granted channel
 - start  out  1  one-cycle pulse on IDLE->PROCESSING
 - done  out  NUM_CH  one-hot done flag to granted channel while in DONE
 - timeout_err  out  1  one-cycle pulse while in TIMEOUT
 - busy  out  1  high in any state other than IDLE

Function
REQ-005 All outputs SHALL be registered or decoded from registered state only; no combinational path from inputs to outputs.
REQ-006 IDLE: when any input_request bit is high, SHALL select one channel by round-robin, latch it into grant/active_ch, pulse start, and enter PROCESSING next cycle.
REQ-007 Round-robin: search SHALL begin at (last granted index + 1) mod NUM_CH; after reset, search begins at channel 0.
REQ-008 Grant SHALL remain stable from IDLE exit until return to IDLE; request changes during a transaction SHALL be ignored.
REQ-009 PROCESSING: output_is_ready high SHALL move to DONE next cycle.
REQ-010 PROCESSING: timer SHALL clear on entry and increment each cycle; when timeout_limit != 0 and timer == timeout_limit - 1 without output_is_ready, SHALL move to TIMEOUT.
REQ-011 Simultaneous output_is_ready and timeout expiry SHALL resolve to DONE.
REQ-012 Timer SHALL saturate at all-ones and never wrap; timeout_limit = 0 SHALL never time out.
REQ-013 DONE: done SHALL equal grant; output_acknowledge[active_ch] high SHALL return to IDLE next cycle; acknowledge on other channels SHALL be ignored.
REQ-014 TIMEOUT: SHALL last exactly one cycle with timeout_err = 1, then enter IDLE; round-robin pointer SHALL advance past the timed-out channel.
REQ-015 abort high in PROCESSING or DONE SHALL enter IDLE next cycle with no done or timeout_err pulse; abort in IDLE or TIMEOUT SHALL have no effect; abort has priority over all other transitions.
REQ-016 A channel holding request high across a return to IDLE SHALL be re-granted only after all other requesting channels are served once.
REQ-017 Minimum transaction: request to start 1 cycle; IDLE->PROCESSING->DONE->IDLE SHALL take 3 cycles when ready and acknowledge are already high.
REQ-018 Unused state encodings SHALL not exist (2-bit fully decoded); any illegal internal value SHALL recover to IDLE.

Reset
REQ-019 On nrst low, asynchronously: state_out = IDLE, grant = 0, active_ch = 0, start = 0, done = 0, timeout_err = 0, busy = 0, timer = 0, round-robin pointer = NUM_CH-1 (next search from channel 0).
REQ-020 Reset mid-transaction SHALL discard the grant with no done or timeout_err pulse.

Verification
REQ-021 Single request: input_request=4'b0100, output_is_ready after 5 cycles, ack[2] -> start pulse once, grant=4'b0100, active_ch=2, done=4'b0100 in DONE, return to IDLE.
REQ-022 Fairness: input_request=4'b1111 held, ready/ack immediate, 8 transactions -> grants in order ch0,1,2,3,0,1,2,3.
REQ-023 Timeout: timeout_limit=8'd10, no ready -> TIMEOUT entered after 10 PROCESSING cycles, timeout_err one cycle, next grant skips that channel; timeout_limit=0 with no ready for 300 cycles -> stays PROCESSING.
REQ-024 Race: ready asserted on the same cycle as timer expiry (limit=4) -> DONE, no timeout_err.
REQ-025 Abort and wrong ack: ack[1] while ch3 granted in DONE -> remains DONE; abort in DONE -> IDLE, done cleared, no pulses.
REQ-026 Async reset asserted in PROCESSING between clock edges -> all outputs at reset values immediately; first request after release granted to ch0.
